// File: rtl/pio_debounce.sv
// ---------------------------------------------------------------------------
// pio_debounce
//
// Multi-channel input conditioner for the SoC PIO input port. Each raw
// asynchronous input is brought into the clk domain through a 2-flop
// synchroniser. It is then debounced against a shared prescaled tick. A new
// level is accepted only after the synchronised input has differed from the
// current debounced level for STABLE consecutive ticks. Accepted transitions
// produce one-cycle rise/fall pulses. These pulses set sticky event flags,
// and the flags drive a masked, registered interrupt.
//
// Ports
//   clk        : SoC clock
//   rst        : synchronous active-high reset
//   raw_i      : [DW] asynchronous raw inputs (switches / buttons)
//   state_o    : [DW] debounced level
//   rise_o     : [DW] one-cycle pulse on an accepted 0->1 transition
//   fall_o     : [DW] one-cycle pulse on an accepted 1->0 transition
//   mask_i     : [DW] per-channel interrupt enable (does not gate evt_o)
//   evt_o      : [DW] sticky edge-event flags
//   evt_clr_i  : [DW] write-1-to-clear strobe for evt_o
//   irq_o      : registered OR of (evt & mask)
// ---------------------------------------------------------------------------
module pio_debounce #(
  parameter int              DW       = 4,
  parameter int              PRESCALE = 65536,
  parameter int              STABLE   = 10,
  parameter logic [DW-1:0]   INIT     = {DW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] raw_i,
  output logic [DW-1:0] state_o,
  output logic [DW-1:0] rise_o,
  output logic [DW-1:0] fall_o,
  input  logic [DW-1:0] mask_i,
  output logic [DW-1:0] evt_o,
  input  logic [DW-1:0] evt_clr_i,
  output logic          irq_o
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int              CW       = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
  localparam logic [PW-1:0]   PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE - 1);

  // Reject parameter values the counters cannot represent sensibly.
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("pio_debounce: PRESCALE must be >= 2");
  end
  if (STABLE < 1) begin : g_bad_stable
    $error("pio_debounce: STABLE must be >= 1");
  end
  if (DW < 1) begin : g_bad_dw
    $error("pio_debounce: DW must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Synchroniser stage: raw -> r_sync1 -> r_sync2
  // -------------------------------------------------------------------------
  logic [DW-1:0] r_sync1;
  logic [DW-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= INIT;
      r_sync2 <= INIT;
    end else begin
      r_sync1 <= raw_i;
      r_sync2 <= r_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Shared prescaler stage: tick is high while the count sits at its last
  // value, so the first tick is consumed PRESCALE edges after reset.
  // -------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel stability counter stage
  // -------------------------------------------------------------------------
  logic [DW-1:0] r_state;
  logic [DW-1:0] w_accept;

  for (genvar g = 0; g < DW; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_last;

    assign w_diff      = r_sync2[g] ^ r_state[g];
    assign w_last      = (r_cnt == CNT_LAST);
    assign w_accept[g] = w_diff & w_tick & w_last;

    // Agreement with the current level clears the count even on a tick, so
    // any bounce back restarts qualification. Acceptance also returns the
    // count to zero, which keeps it within 0..STABLE-1.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (!w_diff || w_accept[g]) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Level / pulse / event / interrupt stage
  // -------------------------------------------------------------------------
  logic [DW-1:0] w_state_nxt;
  logic [DW-1:0] w_rise_nxt;
  logic [DW-1:0] w_fall_nxt;
  logic [DW-1:0] w_evt_nxt;
  logic          w_irq_nxt;
  logic [DW-1:0] r_rise;
  logic [DW-1:0] r_fall;
  logic [DW-1:0] r_evt;
  logic          r_irq;

  assign w_state_nxt = (r_state & ~w_accept) | (r_sync2 & w_accept);
  assign w_rise_nxt  = w_accept &  r_sync2;
  assign w_fall_nxt  = w_accept & ~r_sync2;

  // A new edge takes precedence over a simultaneous clear of the same flag.
  assign w_evt_nxt   = (r_evt & ~evt_clr_i) | w_rise_nxt | w_fall_nxt;

  // Built from the next flag value so irq_o moves in the same cycle as evt_o.
  assign w_irq_nxt   = |(w_evt_nxt & mask_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_rise  <= '0;
      r_fall  <= '0;
      r_evt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_evt   <= w_evt_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign state_o = r_state;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign evt_o   = r_evt;
  assign irq_o   = r_irq;

endmodule

// File: tb/tb_pio_debounce.sv
module tb_pio_debounce;

  localparam int P  = 4;
  localparam int S  = 3;
  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] raw_i;
  logic [DW-1:0] state_o;
  logic [DW-1:0] rise_o;
  logic [DW-1:0] fall_o;
  logic [DW-1:0] mask_i;
  logic [DW-1:0] evt_o;
  logic [DW-1:0] evt_clr_i;
  logic          irq_o;

  int n_checks = 0;
  int n_err    = 0;

  pio_debounce #(
    .DW(DW), .PRESCALE(P), .STABLE(S), .INIT(4'b0000)
  ) dut (
    .clk(clk), .rst(rst), .raw_i(raw_i), .state_o(state_o),
    .rise_o(rise_o), .fall_o(fall_o), .mask_i(mask_i), .evt_o(evt_o),
    .evt_clr_i(evt_clr_i), .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: time since reset decides the tick, the raw input
  // appears two edges later, and a channel adopts its input after S ticks
  // during which input and level disagreed without interruption.
  int            m_cyc;
  logic [DW-1:0] m_d1, m_sync, m_state, m_rise, m_fall, m_evt;
  logic          m_irq;
  int            m_ticks [DW];
  bit            m_valid = 0;
  bit            m_tick;
  logic [DW-1:0] m_rn, m_fn;

  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_d1 = '0; m_sync = '0; m_state = '0;
      m_rise = '0; m_fall = '0; m_evt = '0; m_irq = 1'b0;
      for (int i = 0; i < DW; i++) m_ticks[i] = 0;
      m_valid = 1;
    end else begin
      m_cyc++;
      m_tick = (m_cyc % P) == 0;
      m_rn = '0; m_fn = '0;
      for (int i = 0; i < DW; i++) begin
        if (m_sync[i] == m_state[i]) begin
          m_ticks[i] = 0;
        end else if (m_tick) begin
          m_ticks[i] = m_ticks[i] + 1;
          if (m_ticks[i] == S) begin
            m_state[i] = m_sync[i];
            m_ticks[i] = 0;
            if (m_sync[i]) m_rn[i] = 1'b1; else m_fn[i] = 1'b1;
          end
        end
      end
      m_rise = m_rn;
      m_fall = m_fn;
      m_evt  = (m_evt & ~evt_clr_i) | m_rn | m_fn;
      m_irq  = |(m_evt & mask_i);
      m_sync = m_d1;
      m_d1   = raw_i;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("model_state", 32'(state_o), 32'(m_state));
      check_eq("model_rise",  32'(rise_o),  32'(m_rise));
      check_eq("model_fall",  32'(fall_o),  32'(m_fall));
      check_eq("model_evt",   32'(evt_o),   32'(m_evt));
      check_eq("model_irq",   32'(irq_o),   32'(m_irq));
    end
  end

  int k;

  initial begin
    rst = 1'b1; raw_i = '0; mask_i = '0; evt_clr_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_state", 32'(state_o), 32'h0);
    check_eq("reset_evt",   32'(evt_o),   32'h0);
    check_eq("reset_irq",   32'(irq_o),   32'h0);

    // Single step on channel 0, masked interrupt enabled
    mask_i = 4'b0001; raw_i = 4'b0001; k = 0;
    while (!state_o[0] && k < 50) begin @(negedge clk); k++; end
    check_eq("ch0_latency_in_window", 32'(k >= 11 && k <= 14), 32'h1);
    check_eq("ch0_rise", 32'(rise_o), 32'h1);
    check_eq("ch0_evt",  32'(evt_o),  32'h1);
    check_eq("ch0_irq",  32'(irq_o),  32'h1);
    @(negedge clk);
    check_eq("ch0_rise_one_cycle", 32'(rise_o), 32'h0);
    mask_i = 4'b0000;
    @(negedge clk);
    check_eq("mask_off_irq", 32'(irq_o), 32'h0);
    check_eq("mask_off_evt_kept", 32'(evt_o), 32'h1);

    // Short glitch on channel 1 is rejected, a long hold is accepted
    raw_i[1] = 1'b1;
    repeat (6) @(negedge clk);
    raw_i[1] = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("glitch_state", 32'(state_o), 32'h1);
    check_eq("glitch_evt",   32'(evt_o),   32'h1);
    raw_i[1] = 1'b1; k = 0;
    while (!state_o[1] && k < 30) begin @(negedge clk); k++; end
    check_eq("ch1_rise", 32'(rise_o), 32'h2);
    check_eq("ch1_evt",  32'(evt_o),  32'h3);
    raw_i[1] = 1'b0; k = 0;
    while (state_o[1] && k < 30) begin @(negedge clk); k++; end
    check_eq("ch1_fall", 32'(fall_o), 32'h2);

    // Clear colliding with a new edge: the edge wins
    mask_i = 4'b1111;
    @(negedge clk);
    check_eq("irq_all_mask", 32'(irq_o), 32'h1);
    raw_i[0] = 1'b0; evt_clr_i = 4'b0001; k = 0;
    while (!fall_o[0] && k < 30) begin @(negedge clk); k++; end
    check_eq("clr_vs_edge_fall", 32'(fall_o), 32'h1);
    check_eq("clr_vs_edge_evt0", 32'(evt_o[0]), 32'h1);
    evt_clr_i = 4'b0000;
    @(negedge clk);
    check_eq("evt_after_collision", 32'(evt_o), 32'h3);
    evt_clr_i = 4'b1111;
    @(negedge clk);
    evt_clr_i = 4'b0000;
    check_eq("quiet_clear_evt", 32'(evt_o), 32'h0);
    check_eq("quiet_clear_irq", 32'(irq_o), 32'h0);

    // All channels step together
    raw_i = 4'b1111; k = 0;
    while (state_o == 4'b0000 && k < 30) begin @(negedge clk); k++; end
    check_eq("all_state", 32'(state_o), 32'hF);
    check_eq("all_rise",  32'(rise_o),  32'hF);
    check_eq("all_evt",   32'(evt_o),   32'hF);
    @(negedge clk);
    check_eq("all_rise_one_cycle", 32'(rise_o), 32'h0);

    // Reset with a pending change discards the partial count
    raw_i = 4'b0000; k = 0;
    while (state_o != 4'b0000 && k < 30) begin @(negedge clk); k++; end
    evt_clr_i = 4'b1111;
    @(negedge clk);
    evt_clr_i = 4'b0000;
    raw_i[2] = 1'b1;
    repeat (9) @(negedge clk);
    check_eq("pending_not_yet", 32'(state_o), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_state", 32'(state_o), 32'h0);
    check_eq("midrst_rise",  32'(rise_o),  32'h0);
    check_eq("midrst_evt",   32'(evt_o),   32'h0);
    k = 0;
    while (!state_o[2] && k < 40) begin @(negedge clk); k++; end
    check_eq("post_rst_full_delay", 32'(k), 32'd12);
    check_eq("post_rst_rise", 32'(rise_o), 32'h4);

    // Randomised bouncing, masks, clears and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < DW; i++)
        if ($urandom_range(15) == 0) raw_i[i] = ~raw_i[i];
      if ($urandom_range(31) == 0) mask_i = 4'($urandom_range(15));
      evt_clr_i = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'b0000;
      rst = ($urandom_range(599) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
